// File: rtl/scan_pkg.sv
// Shared constants and FSM state encoding for the scan sequencer.
// Latency: none (types and constants only).
// Backpressure: none.
package scan_pkg;

    localparam int NUM_LINES = 8;
    localparam int SEL_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/scan_next_sel.sv
// Wrap-around priority finder: next enabled line above cur, or the lowest one.
// Latency: purely combinational.
// Backpressure: none.
module scan_next_sel
    import scan_pkg::*;
(
    input  logic [NUM_LINES-1:0] mask,
    input  logic [SEL_W-1:0]     cur,
    input  logic                 from_zero,
    output logic [SEL_W-1:0]     next,
    output logic                 wrapped
);

    logic [SEL_W-1:0] low_idx;
    logic [SEL_W-1:0] above_idx;
    logic             found_above;

    // Descending scans so the lowest qualifying index is the one left standing.
    // With from_zero every enabled bit qualifies, so the search starts at bit 0.
    always_comb begin
        low_idx     = '0;
        above_idx   = '0;
        found_above = 1'b0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = SEL_W'(i);
                if (from_zero || (SEL_W'(i) > cur)) begin
                    above_idx   = SEL_W'(i);
                    found_above = 1'b1;
                end
            end
        end
        next    = found_above ? above_idx : low_idx;
        wrapped = ~found_above;
    end

endmodule

// File: rtl/scan_sequencer_3x8.sv
// Steps a 3-bit decoder select through enabled lines with a dwell plus a 1-cycle gap.
// Latency: start sampled at edge k gives sel_valid/busy from edge k; all outputs registered.
// Backpressure: none; start ignored while busy, stop takes effect at the frame end.
module scan_sequencer_3x8
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 cont,
    input  logic [NUM_LINES-1:0] mask,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [SEL_W-1:0]     sel,
    output logic                 sel_valid,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err
);

    localparam logic [DWELL_W-1:0] ONE_C = DWELL_W'(1);

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   sel_valid_q, sel_valid_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_q, err_d;
    logic [DWELL_W-1:0]     cnt_q, cnt_d;
    logic [NUM_LINES-1:0]   mask_q, mask_d;
    logic [DWELL_W-1:0]     dwell_q, dwell_d;
    logic                   cont_q, cont_d;
    logic                   stop_pend_q, stop_pend_d;

    logic [DWELL_W-1:0]     dwell_eff;
    logic                   from_zero;
    logic [NUM_LINES-1:0]   find_mask;
    logic [SEL_W-1:0]       nxt_sel;
    logic                   nxt_wrapped;

    assign dwell_eff = (|dwell) ? dwell : ONE_C;

    // A frame boundary (frame_done_q high in GAP) restarts the search from the
    // freshly sampled mask, exactly like a start from IDLE does.
    assign from_zero = (state_q == IDLE) || ((state_q == GAP) && frame_done_q);
    assign find_mask = from_zero ? mask : mask_q;

    scan_next_sel u_next_sel (
        .mask      (find_mask),
        .cur       (sel_q),
        .from_zero (from_zero),
        .next      (nxt_sel),
        .wrapped   (nxt_wrapped)
    );

    // Next-state logic; frame_done is decided when leaving DWELL so it is a
    // registered pulse aligned with the GAP cycle that ends the frame.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        dwell_d      = dwell_q;
        cont_d       = cont_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        stop_pend_d  = stop_pend_q | (stop && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (|mask) begin
                        mask_d  = mask;
                        dwell_d = dwell_eff;
                        cont_d  = cont;
                        sel_d   = nxt_sel;
                        cnt_d   = dwell_eff - ONE_C;
                        state_d = DWELL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (|cnt_q) begin
                    cnt_d = cnt_q - ONE_C;
                end else begin
                    state_d      = GAP;
                    frame_done_d = nxt_wrapped;
                end
            end
            GAP: begin
                if (frame_done_q) begin
                    if (stop_pend_q || !cont_q) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        mask_d  = mask;
                        dwell_d = dwell_eff;
                        if (|mask) begin
                            sel_d   = nxt_sel;
                            cnt_d   = dwell_eff - ONE_C;
                            state_d = DWELL;
                        end else begin
                            state_d     = IDLE;
                            err_d       = 1'b1;
                            stop_pend_d = 1'b0;
                        end
                    end
                end else begin
                    sel_d   = nxt_sel;
                    cnt_d   = dwell_q - ONE_C;
                    state_d = DWELL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sel_valid_d = (state_d == DWELL);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            sel_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            mask_q       <= '0;
            dwell_q      <= '0;
            cont_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            sel_valid_q  <= sel_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            dwell_q      <= dwell_d;
            cont_q       <= cont_d;
            stop_pend_q  <= stop_pend_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_scan_sequencer_3x8.sv
// Scoreboard bench: stimulus pushes expected (cycle, sel), frame_done and err events.
// A negedge monitor pops and compares whenever the DUT asserts an output.
module tb_scan_sequencer_3x8;

    logic       clk = 1'b0;
    logic       rst, start, stop, cont;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       sel_valid, busy, frame_done, err;

    scan_sequencer_3x8 #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .mask       (mask),
        .dwell      (dwell),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int s;
    } exp_t;

    exp_t q_sel[$];
    int   q_fd[$];
    int   q_err[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Push the expected events of one frame whose first DWELL cycle is base+1.
    task automatic expect_frame(input int base, input logic [7:0] m, input int d,
                                output int fend);
        int de;
        int j;
        exp_t e;
        de = (d == 0) ? 1 : d;
        j  = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                for (int t = 0; t < de; t++) begin
                    e.c = base + 1 + j * (de + 1) + t;
                    e.s = i;
                    q_sel.push_back(e);
                end
                j++;
            end
        end
        fend = base + j * (de + 1);
        q_fd.push_back(fend);
    endtask

    // Called at a negedge: drive a start pulse this cycle and queue its frame.
    task automatic start_frame(input logic [7:0] m, input int d, input logic c,
                               output int s, output int fend);
        s = cyc;
        expect_frame(s, m, d, fend);
        mask  = m;
        dwell = 8'(d);
        cont  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compare every asserted output against the head of its queue.
    exp_t e_mon;
    always @(negedge clk) begin
        if (sel_valid) begin
            if (q_sel.size() == 0) begin
                chk("sel_valid_extra", int'(sel_valid), 0);
            end else begin
                e_mon = q_sel.pop_front();
                chk("sel_cycle", cyc, e_mon.c);
                chk("sel", int'(sel), e_mon.s);
            end
        end
        if (frame_done) begin
            if (q_fd.size() == 0) chk("frame_done_extra", int'(frame_done), 0);
            else                  chk("frame_done_cycle", cyc, q_fd.pop_front());
        end
        if (err) begin
            if (q_err.size() == 0) chk("err_extra", int'(err), 0);
            else                   chk("err_cycle", cyc, q_err.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s, fe, f2, f3, f4;

        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
        mask = 8'h00; dwell = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_sel", int'(sel), 0);
        chk("rst_sel_valid", int'(sel_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full mask, dwell 3, single frame: 32-cycle frame.
        start_frame(8'hFF, 3, 1'b0, s, fe);
        wait_cycle(s + 1);
        chk("busy_after_start", int'(busy), 1);
        wait_cycle(fe);
        chk("busy_last_gap", int'(busy), 1);
        chk("sel_valid_last_gap", int'(sel_valid), 0);
        chk("sel_hold_last_gap", int'(sel), 7);
        wait_cycle(fe + 1);
        chk("busy_after_frame_ff", int'(busy), 0);
        repeat (3) @(negedge clk);

        // Sparse mask 2,5,7 with dwell 1: 6-cycle frame.
        start_frame(8'b1010_0100, 1, 1'b0, s, fe);
        wait_cycle(fe + 1);
        chk("busy_after_frame_a4", int'(busy), 0);
        repeat (2) @(negedge clk);

        // Empty mask: err pulse only.
        s = cyc;
        q_err.push_back(s + 1);
        mask  = 8'h00;
        dwell = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_busy", int'(busy), 0);
        chk("err_sel_valid", int'(sel_valid), 0);
        repeat (3) @(negedge clk);

        // Continuous with stop at sel=3: frame finishes, no restart.
        start_frame(8'hFF, 2, 1'b1, s, fe);
        wait_cycle(s + 1 + 3 * 3);
        chk("stop_at_sel3", int'(sel), 3);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_cycle(fe + 1);
        chk("busy_after_stop", int'(busy), 0);
        repeat (6) @(negedge clk);
        cont = 1'b0;

        // Continuous, mask changed to 8'h01 mid-frame at sel=2.
        start_frame(8'hFF, 1, 1'b1, s, fe);
        wait_cycle(s + 5);
        chk("mask_change_at_sel2", int'(sel), 2);
        mask = 8'h01;
        expect_frame(fe, 8'h01, 1, f2);
        expect_frame(f2, 8'h01, 1, f3);
        expect_frame(f3, 8'h01, 1, f4);
        wait_cycle(f3 + 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_cycle(f4 + 1);
        chk("busy_after_single_line", int'(busy), 0);
        cont = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during DWELL, then immediate start with dwell 0.
        s = cyc;
        e_push(s + 1, 0);
        e_push(s + 2, 0);
        mask  = 8'hFF;
        dwell = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cycle(s + 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_sel", int'(sel), 0);
        chk("midrst_sel_valid", int'(sel_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_frame_done", int'(frame_done), 0);
        chk("midrst_err", int'(err), 0);
        start_frame(8'h10, 0, 1'b0, s, fe);
        wait_cycle(fe + 1);
        chk("busy_after_dwell0", int'(busy), 0);
        repeat (5) @(negedge clk);

        chk("sel_queue_left", q_sel.size(), 0);
        chk("frame_done_queue_left", q_fd.size(), 0);
        chk("err_queue_left", q_err.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic e_push(input int c, input int s);
        exp_t e;
        e.c = c;
        e.s = s;
        q_sel.push_back(e);
    endtask

endmodule
